// File: rtl/tnn_pkg.sv
// Shared constants, state encoding and reference quantiser for the ternary-neuron
// feature interface.
package tnn_pkg;

    localparam int TNN_NUM_FEAT = 5;
    localparam int TNN_IN_W     = 8;
    localparam int TNN_Q_W      = 3;

    typedef enum logic {ST_FILL, ST_HOLD} tnn_state_t;

    // Round half-up to the nearest Q_W-bit code, saturating at the top code.
    function automatic logic [TNN_Q_W-1:0] tnn_quantise(input logic [TNN_IN_W-1:0] x);
        logic [TNN_IN_W:0] sum;
        logic [TNN_IN_W:0] shifted;
        sum     = {1'b0, x} + (TNN_IN_W+1)'(1 << (TNN_IN_W - TNN_Q_W - 1));
        shifted = sum >> (TNN_IN_W - TNN_Q_W);
        if (shifted > (TNN_IN_W+1)'((1 << TNN_Q_W) - 1)) begin
            return '1;
        end
        return shifted[TNN_Q_W-1:0];
    endfunction

endpackage

// File: rtl/tnn_quant_sat.sv
// Combinational round-to-nearest (half-up) and saturate from IN_W to Q_W bits.
module tnn_quant_sat
    import tnn_pkg::*;
#(
    parameter int IN_W = TNN_IN_W,
    parameter int Q_W  = TNN_Q_W
) (
    input  logic [IN_W-1:0] x,
    output logic [Q_W-1:0]  q
);

    localparam int SH = IN_W - Q_W;
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);
    localparam logic [IN_W:0] QMAX = (IN_W+1)'((1 << Q_W) - 1);

    // One extra sum bit so the rounding offset never wraps the top codes.
    function automatic logic [Q_W-1:0] round_sat(input logic [IN_W-1:0] v);
        logic [IN_W:0] sum;
        logic [IN_W:0] shifted;
        sum     = {1'b0, v} + HALF;
        shifted = sum >> SH;
        if (shifted > QMAX) begin
            return '1;
        end
        return shifted[Q_W-1:0];
    endfunction

    assign q = round_sat(x);

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantises a stream of raw features and packs NUM_FEAT of them into one vector
// for the downstream ternary neuron, with valid/ready on both sides.
module tnn_feature_packer
    import tnn_pkg::*;
#(
    parameter int NUM_FEAT = TNN_NUM_FEAT,
    parameter int IN_W     = TNN_IN_W,
    parameter int Q_W      = TNN_Q_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_first,
    input  logic [IN_W-1:0]         s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NUM_FEAT*Q_W-1:0] m_data,
    output logic                    frame_err
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    tnn_state_t               state;
    tnn_state_t               state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [IDX_W-1:0]         wr_idx;
    logic [Q_W-1:0]           slot [NUM_FEAT];
    logic [Q_W-1:0]           q_val;
    logic [NUM_FEAT*Q_W-1:0]  packed_vec;
    logic [NUM_FEAT*Q_W-1:0]  data_p1;
    logic                     vld_p1;
    logic                     err_p1;
    logic                     rdy_en;
    logic                     in_xfer;
    logic                     out_xfer;
    logic                     resync;
    logic                     frame_done;

    tnn_quant_sat #(
        .IN_W (IN_W),
        .Q_W  (Q_W)
    ) u_quant (
        .x (s_data),
        .q (q_val)
    );

    // rdy_en keeps s_ready low until the first clock after reset release.
    assign vld_p1    = (state == ST_HOLD);
    assign s_ready   = rdy_en & ((state == ST_FILL) | m_ready);
    assign in_xfer   = s_valid & s_ready;
    assign out_xfer  = vld_p1 & m_ready;
    assign m_valid   = vld_p1;
    assign m_data    = data_p1;
    assign frame_err = err_p1;

    always_comb begin
        resync    = 1'b0;
        wr_idx    = idx;
        idx_nxt   = idx;
        state_nxt = state;
        if (state == ST_HOLD) begin
            wr_idx = '0;
        end else if (s_first && (idx != '0)) begin
            resync = 1'b1;
            wr_idx = '0;
        end
        frame_done = in_xfer && (wr_idx == LAST_IDX);
        if (in_xfer) begin
            idx_nxt = frame_done ? '0 : wr_idx + IDX_W'(1);
        end
        if (frame_done) begin
            state_nxt = ST_HOLD;
        end else if (out_xfer) begin
            state_nxt = ST_FILL;
        end
    end

    // The sample completing a frame bypasses its slot straight into the output vector.
    always_comb begin
        packed_vec = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            packed_vec[k*Q_W +: Q_W] = (IDX_W'(k) == wr_idx) ? q_val : slot[k];
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            slot[wr_idx] <= q_val;
        end
    end

    // Stage p1: registered vector, valid and resync pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FILL;
            idx     <= '0;
            rdy_en  <= 1'b0;
            err_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            rdy_en <= 1'b1;
            err_p1 <= in_xfer & resync;
            if (frame_done) begin
                data_p1 <= packed_vec;
            end
        end
    end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Bench for tnn_feature_packer: queue-based frame model checked every cycle, plus
// directed vectors with literal expected vectors.
module tb_tnn_feature_packer;

    localparam int NF = 5;
    localparam int IW = 8;
    localparam int QW = 3;
    localparam int VW = NF * QW;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          s_valid    = 1'b0;
    logic          s_first    = 1'b0;
    logic [IW-1:0] s_data     = '0;
    logic          dir_ready  = 1'b1;
    logic          rnd_ready  = 1'b0;
    logic          rand_phase = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_data;
    logic          frame_err;

    int compared   = 0;
    int mismatched = 0;

    int            mbuf[$];
    logic [VW-1:0] exp_q[$];
    logic          err_exp = 1'b0;
    logic          armed   = 1'b0;
    int            made    = 0;
    int            outs    = 0;

    assign m_ready = rand_phase ? rnd_ready : dir_ready;

    always #5 clk = ~clk;

    tnn_feature_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_first   (s_first),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err)
    );

    function automatic int ref_q(input int x);
        int r;
        r = (x + 2 ** (IW - QW - 1)) / (2 ** (IW - QW));
        return (r > 2 ** QW - 1) ? 2 ** QW - 1 : r;
    endfunction

    function automatic logic [VW-1:0] pack(input int f[$]);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NF; k++) begin
            v = v | (VW'(f[k]) << (k * QW));
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send(input logic [IW-1:0] d, input logic f);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: s_ready still 0, required 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Frame model: evaluates what the outputs must be now, then applies this
    // cycle's handshakes for the coming edge.
    always @(negedge clk) begin
        logic exp_srdy;
        logic in_x;
        logic out_x;
        if (!rst_n) begin
            check("rst_m_valid", m_valid, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_m_data", m_data, 0);
            made -= exp_q.size();
            mbuf.delete();
            exp_q.delete();
            err_exp = 1'b0;
            armed   = 1'b0;
        end else begin
            exp_srdy = armed && ((exp_q.size() == 0) || m_ready);
            check("s_ready", s_ready, exp_srdy);
            check("m_valid", m_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0]);
            end
            check("frame_err", frame_err, err_exp);
            in_x    = s_valid && exp_srdy;
            out_x   = (exp_q.size() != 0) && m_ready;
            err_exp = 1'b0;
            if (out_x) begin
                void'(exp_q.pop_front());
                outs++;
            end
            if (in_x) begin
                if (s_first && mbuf.size() != 0) begin
                    mbuf.delete();
                    err_exp = 1'b1;
                end
                mbuf.push_back(ref_q(int'(s_data)));
                if (mbuf.size() == NF) begin
                    exp_q.push_back(pack(mbuf));
                    made++;
                    mbuf.delete();
                end
            end
            armed = 1'b1;
        end
    end

    initial begin
        int xs[7];
        int qs[7];
        int out_base;
        xs = '{0, 15, 16, 100, 239, 240, 255};
        qs = '{0, 0, 1, 3, 7, 7, 7};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_reset", s_ready, 1);
        check("m_valid_after_reset", m_valid, 0);

        for (int k = 0; k < 7; k++) begin
            s_data = 8'(xs[k]);
            #1;
            check("quant_literal", dut.q_val, qs[k]);
            check("ref_literal", ref_q(xs[k]), qs[k]);
        end
        for (int x = 0; x < 256; x++) begin
            s_data = x[7:0];
            #1;
            check("quant_sweep", dut.q_val, ref_q(x));
        end
        @(posedge clk);
        #1;

        dir_ready = 1'b1;
        send(8'd16, 1'b1);
        send(8'd48, 1'b0);
        send(8'd80, 1'b0);
        send(8'd112, 1'b0);
        send(8'd144, 1'b0);
        check("frame_latency_valid", m_valid, 1);
        check("frame_data", m_data, 15'o54321);

        @(posedge clk);
        #1;
        dir_ready = 1'b0;
        send(8'd0, 1'b1);
        send(8'd32, 1'b0);
        send(8'd64, 1'b0);
        send(8'd96, 1'b0);
        send(8'd128, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data", m_data, 15'o43210);
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        send(8'd255, 1'b0);
        check("bp_consumed", m_valid, 0);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
        check("bp_next_valid", m_valid, 1);
        check("bp_next_data", m_data, 15'o00007);

        @(posedge clk);
        #1;
        send(8'd32, 1'b1);
        send(8'd32, 1'b0);
        send(8'd32, 1'b0);
        send(8'd255, 1'b1);
        check("resync_err_pulse", frame_err, 1);
        @(posedge clk);
        #1;
        check("resync_err_clear", frame_err, 0);
        for (int i = 0; i < 4; i++) send(8'd16, 1'b0);
        check("resync_frame_valid", m_valid, 1);
        check("resync_frame_data", m_data, 15'o11117);

        @(posedge clk);
        #1;
        dir_ready = 1'b0;
        send(8'd0, 1'b1);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_before_reset", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_hold_m_valid", m_valid, 0);
        check("reset_hold_frame_err", frame_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'd32, 1'b1);
        send(8'd32, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_fill_m_valid", m_valid, 0);
        check("reset_fill_frame_err", frame_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dir_ready = 1'b1;
        send(8'd224, 1'b0);
        send(8'd192, 1'b0);
        send(8'd160, 1'b0);
        send(8'd128, 1'b0);
        send(8'd96, 1'b0);
        check("post_reset_valid", m_valid, 1);
        check("post_reset_data", m_data, 15'o34567);

        @(posedge clk);
        #1;
        out_base   = outs;
        rand_phase = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < NF; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(8'($urandom_range(0, 255)), (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end
        rand_phase = 1'b0;
        dir_ready  = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("random_frames_out", outs - out_base, 1000);
        check("frames_made_vs_out", outs, made);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
